// File: rtl/cg_pkg.sv
// Shared definitions for the multi-channel clock-gating controller:
// channel state encoding, stats counter width and the WAKE_DLY range check.
package cg_pkg;

  // Per-channel controller states (encoding fixed: OFF=0 .. GATED=4)
  typedef enum logic [2:0] {
    CG_OFF   = 3'd0,
    CG_WAKE  = 3'd1,
    CG_RUN   = 3'd2,
    CG_IDLE  = 3'd3,
    CG_GATED = 3'd4
  } cg_state_e;

  // Width of each gated/off residency counter (optional stats block)
  localparam int CG_STAT_W = 16;

  // WAKE must last at least one edge, otherwise the clock would be reported
  // ready in the same cycle it is switched on.
  function automatic bit cg_wake_dly_ok(input int dly);
    return dly >= 1;
  endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: negative-level latch on the enable followed by an AND.
// This is the single place to drop in a library ICG cell later.
module clk_gate_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_lat;

  // Enable may only change while clk is low, so gclk never starts or ends mid-pulse
  always_latch begin
    if (!clk) en_lat <= en | test_en;
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl_mc.sv
// Multi-channel clock-gating controller. Each channel owns a small FSM
// (OFF/WAKE/RUN/IDLE/GATED), an idle timeout counter, a wake delay counter and
// one clk_gate_cell. Channels share only clk, rst_n, idle_thresh and test_en.
// Optional build macro CG_STATS_EN adds per-channel gated/off residency
// counters readable through stat_sel/stat_cnt and cleared by stat_clr.
module clk_gate_ctrl_mc
  import cg_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       sw_en,
  input  logic [NUM_CH-1:0]       busy,
  input  logic [NUM_CH-1:0]       wake_req,
  input  logic [IDLE_CNT_W-1:0]   idle_thresh,
  input  logic                    test_en,
`ifdef CG_STATS_EN
  input  logic [$clog2(NUM_CH)-1:0] stat_sel,
  input  logic                    stat_clr,
  output logic [CG_STAT_W-1:0]    stat_cnt,
`endif
  output logic [NUM_CH-1:0]       gated_clk,
  output logic [NUM_CH-1:0]       ch_ready
);

  // Wake counter sized to hold WAKE_DLY-1 even when WAKE_DLY is 1
  localparam int WK_W = $clog2(WAKE_DLY + 1);
  localparam logic [WK_W-1:0] WAKE_LAST = WK_W'(WAKE_DLY - 1);

  if (!cg_wake_dly_ok(WAKE_DLY)) begin : g_bad_wake_dly
    $error("clk_gate_ctrl_mc: WAKE_DLY must be >= 1");
  end

`ifdef CG_STATS_EN
  logic [NUM_CH-1:0] clk_off;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cg_state_e              state_q, state_d;
    logic [IDLE_CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [WK_W-1:0]        wake_cnt_q, wake_cnt_d;
    logic                   en_q, en_d;
    logic                   rdy_q, rdy_d;

    // Next-state logic; sw_en low overrides everything and forces OFF
    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      if (!sw_en[c]) begin
        state_d = CG_OFF;
      end else begin
        unique case (state_q)
          CG_OFF: begin
            state_d    = CG_WAKE;
            wake_cnt_d = '0;
          end
          CG_WAKE: begin
            if (wake_cnt_q == WAKE_LAST) state_d = CG_RUN;
            else                         wake_cnt_d = wake_cnt_q + 1'b1;
          end
          CG_RUN: begin
            if (!busy[c]) begin
              state_d    = CG_IDLE;
              idle_cnt_d = IDLE_CNT_W'(1);
            end
          end
          CG_IDLE: begin
            if (busy[c]) begin
              state_d    = CG_RUN;
              idle_cnt_d = '0;
            end else if (idle_thresh != '0 && idle_cnt_q == idle_thresh) begin
              state_d = CG_GATED;
            end else if (idle_cnt_q != '1) begin
              // Saturate so a threshold lowered below the count parks in IDLE
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
          CG_GATED: begin
            if (busy[c] || wake_req[c]) begin
              state_d    = CG_WAKE;
              wake_cnt_d = '0;
            end
          end
          default: state_d = CG_OFF;
        endcase
      end
      // Outputs are decoded from the next state and registered, so the clock
      // enable and ready flag change on the same edge as the state itself.
      en_d  = (state_d == CG_WAKE) || (state_d == CG_RUN) || (state_d == CG_IDLE);
      rdy_d = (state_d == CG_RUN)  || (state_d == CG_IDLE);
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= CG_OFF;
        idle_cnt_q <= '0;
        wake_cnt_q <= '0;
        en_q       <= 1'b0;
        rdy_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
        wake_cnt_q <= wake_cnt_d;
        en_q       <= en_d;
        rdy_q      <= rdy_d;
      end
    end

    assign ch_ready[c] = rdy_q;

`ifdef CG_STATS_EN
    assign clk_off[c] = (state_q == CG_OFF) || (state_q == CG_GATED);
`endif

    // en_q changes just after the edge; the cell picks it up in the low phase
    clk_gate_cell u_gate (
      .clk     (clk),
      .en      (en_q),
      .test_en (test_en),
      .gclk    (gated_clk[c])
    );
  end

`ifdef CG_STATS_EN
  logic [NUM_CH-1:0][CG_STAT_W-1:0] stat_q, stat_d;

  // Count edges spent with the clock stopped; clear takes precedence
  always_comb begin
    stat_d = stat_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (stat_clr)                          stat_d[c] = '0;
      else if (clk_off[c] && stat_q[c] != '1) stat_d[c] = stat_q[c] + 1'b1;
    end
  end

  // Residency counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_clk_gate_ctrl_mc.sv
// Scoreboard bench for clk_gate_ctrl_mc: a driver applies stimulus just after
// each rising edge, steps a behavioural model and queues the outputs expected
// after the following edge; a monitor samples the DUT mid high phase and
// compares. A per-channel watcher checks every gated pulse is a full half period.
module tb_clk_gate_ctrl_mc;

  localparam int NCH = 4;
  localparam int IW  = 8;
  localparam int WD  = 2;
  localparam int PER = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  sw_en, busy, wake_req;
  logic [IW-1:0]   idle_thresh;
  logic            test_en;
  logic [NCH-1:0]  gated_clk, ch_ready;
`ifdef CG_STATS_EN
  logic [1:0]      stat_sel;
  logic            stat_clr;
  logic [15:0]     stat_cnt;
`endif

  clk_gate_ctrl_mc #(.NUM_CH(NCH), .IDLE_CNT_W(IW), .WAKE_DLY(WD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_en       (sw_en),
    .busy        (busy),
    .wake_req    (wake_req),
    .idle_thresh (idle_thresh),
    .test_en     (test_en),
`ifdef CG_STATS_EN
    .stat_sel    (stat_sel),
    .stat_clr    (stat_clr),
    .stat_cnt    (stat_cnt),
`endif
    .gated_clk   (gated_clk),
    .ch_ready    (ch_ready)
  );

  always #(PER/2) clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_OFF, M_WAKE, M_RUN, M_IDLE, M_GATED} mode_e;

  typedef struct {
    logic [NCH-1:0] sw, b, w;
    int             thr;
    logic           te;
    int             sel;
    logic           clr;
  } stim_t;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] pulse;
    int             st;
  } exp_t;

  mode_e mode   [NCH];
  int    wake_edges [NCH];   // edges already spent waking
  int    zero_streak[NCH];   // consecutive busy=0 samples since leaving RUN
  int    stat   [NCH];
  exp_t  q[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mode[c] = M_OFF; wake_edges[c] = 0; zero_streak[c] = 0; stat[c] = 0;
    end
  endtask

  function automatic stim_t mk(input logic [NCH-1:0] sw, b, w, input int thr, input logic te);
    stim_t s;
    s.sw = sw; s.b = b; s.w = w; s.thr = thr; s.te = te; s.sel = 0; s.clr = 1'b0;
    return s;
  endfunction

  // Apply inputs now and queue what the DUT must show after the next edge
  task automatic apply(input stim_t s);
    exp_t e;
    sw_en = s.sw; busy = s.b; wake_req = s.w; idle_thresh = IW'(s.thr); test_en = s.te;
`ifdef CG_STATS_EN
    stat_sel = 2'(s.sel); stat_clr = s.clr;
`endif
    e.cyc = cyc + 1;
    for (int c = 0; c < NCH; c++) begin
      // the clock runs in the coming high phase iff it was enabled now (or bypassed)
      e.pulse[c] = (mode[c] inside {M_WAKE, M_RUN, M_IDLE}) || s.te;
      if (s.clr) stat[c] = 0;
      else if (mode[c] inside {M_OFF, M_GATED}) stat[c] = (stat[c] < 65535) ? stat[c] + 1 : 65535;
      if (!s.sw[c]) mode[c] = M_OFF;
      else case (mode[c])
        M_OFF:   begin mode[c] = M_WAKE; wake_edges[c] = 0; end
        M_WAKE:  begin
          wake_edges[c]++;
          if (wake_edges[c] == WD) mode[c] = M_RUN;
        end
        M_RUN:   if (!s.b[c]) begin mode[c] = M_IDLE; zero_streak[c] = 1; end
        M_IDLE:  if (s.b[c]) begin mode[c] = M_RUN; zero_streak[c] = 0; end
                 else if (s.thr != 0 && zero_streak[c] == s.thr) mode[c] = M_GATED;
                 else if (zero_streak[c] < 255) zero_streak[c]++;
        M_GATED: if (s.b[c] || s.w[c]) begin mode[c] = M_WAKE; wake_edges[c] = 0; end
        default: mode[c] = M_OFF;
      endcase
      e.rdy[c] = mode[c] inside {M_RUN, M_IDLE};
    end
    e.st = stat[s.sel];
    q.push_back(e);
  endtask

  task automatic cyc_drive(input stim_t s);
    @(posedge clk); #1;
    apply(s);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); cyc++;
      #2;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("ch_ready", 32'(ch_ready), 32'(e.rdy));
        chk("gated_clk pulse", 32'(gated_clk), 32'(e.pulse));
`ifdef CG_STATS_EN
        chk("stat_cnt", 32'(stat_cnt), 32'(e.st));
`endif
      end
    end
  end

  // Every gated pulse must span exactly the clk high phase
  for (genvar g = 0; g < NCH; g++) begin : g_pw
    initial begin
      time t_r;
      forever begin
        @(posedge gated_clk[g]); t_r = $time;
        @(negedge gated_clk[g]);
        chk("gated_clk pulse width", 32'($time - t_r), 32'(PER/2));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    logic [NCH-1:0] bvec, wvec;
    int thr;
    rst_n = 1'b0; sw_en = '0; busy = '0; wake_req = '0; idle_thresh = '0; test_en = 1'b0;
`ifdef CG_STATS_EN
    stat_sel = '0; stat_clr = 1'b0;
`endif
    model_reset();
    #2;
    chk("reset ch_ready", 32'(ch_ready), 0);
    chk("reset gated_clk low phase", 32'(gated_clk), 0);
    sw_en = '1; busy = '1;
    #5;
    chk("reset gated_clk high phase", 32'(gated_clk), 0);

    // 1: power-up of all channels
    @(posedge clk); #1; rst_n = 1'b1;
    apply(mk('1, '1, '0, 4, 1'b0));
    repeat (3) cyc_drive(mk('1, '1, '0, 4, 1'b0));
    // 2/3: all go idle; ch1 returns busy after 3 idle edges, others gate
    repeat (3) cyc_drive(mk('1, 4'b0000, '0, 4, 1'b0));
    repeat (4) cyc_drive(mk('1, 4'b0010, '0, 4, 1'b0));
    // 4: wake ch2 by request, held until ready
    repeat (3) cyc_drive(mk('1, 4'b0010, 4'b0100, 4, 1'b0));
    repeat (6) cyc_drive(mk('1, 4'b0010, '0, 4, 1'b0));
    // 5: scan bypass on gated channels, then off again
    repeat (4) cyc_drive(mk('1, 4'b0010, '0, 4, 1'b1));
    repeat (4) cyc_drive(mk('1, 4'b0010, '0, 4, 1'b0));

`ifdef CG_STATS_EN
    // ch0 held OFF for 10 edges after a clear, then cleared again
    s = mk(4'b1110, 4'b0010, '0, 4, 1'b0); s.clr = 1'b1;
    cyc_drive(s);
    s.clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc_drive(s);
      if (i == 9) fork begin #11; chk("stat_cnt after 10 off edges", 32'(stat_cnt), 10); end join_none
    end
    s.clr = 1'b1;
    cyc_drive(s);
    fork begin #11; chk("stat_cnt after clear", 32'(stat_cnt), 0); end join_none
    s.clr = 1'b0;
    cyc_drive(s);
`endif

    // random traffic
    bvec = '1; wvec = '0; thr = 3;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) bvec[c] = ~bvec[c];
        if (wvec[c] && mode[c] inside {M_RUN, M_IDLE}) wvec[c] = 1'b0;
        else if (!wvec[c] && mode[c] == M_GATED && $urandom_range(0, 3) == 0) wvec[c] = 1'b1;
        s.sw[c] = ($urandom_range(0, 40) != 0);
      end
      if ($urandom_range(0, 49) == 0) thr = $urandom_range(0, 6);
      s.b = bvec; s.w = wvec; s.thr = thr;
      s.te  = ($urandom_range(0, 15) == 0);
      s.sel = $urandom_range(0, NCH-1);
      s.clr = ($urandom_range(0, 63) == 0);
      cyc_drive(s);
    end

    // 6: async reset in the middle of WAKE
    cyc_drive(mk('0, '1, '0, 4, 1'b0));
    cyc_drive(mk('1, '1, '0, 4, 1'b0));
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ch_ready under reset", 32'(ch_ready), 0);
    @(negedge clk); #1;
    chk("gated_clk low after reset", 32'(gated_clk), 0);
    @(posedge clk); #2;
    chk("gated_clk high phase under reset", 32'(gated_clk), 0);
`ifdef CG_STATS_EN
    chk("stat_cnt under reset", 32'(stat_cnt), 0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    apply(mk('1, '1, '0, 4, 1'b0));
    repeat (6) cyc_drive(mk('1, '1, '0, 4, 1'b0));

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
